// File: rtl/pio_pkg.sv
// Shared definitions for the PIO APB front end: core action codes,
// register offsets and the bridge FSM state encoding.
package pio_pkg;

    localparam int unsigned ACTION_W = 6;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_SM   = 4;

    // Action codes understood by the PIO core
    localparam logic [ACTION_W-1:0] ACT_NONE           = 6'd0;
    localparam logic [ACTION_W-1:0] ACT_INSTR          = 6'd1;
    localparam logic [ACTION_W-1:0] ACT_PEND           = 6'd2;
    localparam logic [ACTION_W-1:0] ACT_PULL           = 6'd3;
    localparam logic [ACTION_W-1:0] ACT_PUSH           = 6'd4;
    localparam logic [ACTION_W-1:0] ACT_GRPS           = 6'd5;
    localparam logic [ACTION_W-1:0] ACT_EN             = 6'd6;
    localparam logic [ACTION_W-1:0] ACT_DIV            = 6'd7;
    localparam logic [ACTION_W-1:0] ACT_IMM            = 6'd9;
    localparam logic [ACTION_W-1:0] ACT_SHIFT          = 6'd10;
    localparam logic [ACTION_W-1:0] ACT_RD_IRQ         = 6'd11;
    localparam logic [ACTION_W-1:0] ACT_RD_INTR        = 6'd12;
    localparam logic [ACTION_W-1:0] ACT_RD_IRQ0_INTE   = 6'd13;
    localparam logic [ACTION_W-1:0] ACT_RD_IRQ0_INTF   = 6'd14;
    localparam logic [ACTION_W-1:0] ACT_RD_IRQ0_INTS   = 6'd15;
    localparam logic [ACTION_W-1:0] ACT_RD_IRQ1_INTE   = 6'd16;
    localparam logic [ACTION_W-1:0] ACT_RD_IRQ1_INTF   = 6'd17;
    localparam logic [ACTION_W-1:0] ACT_RD_IRQ1_INTS   = 6'd18;
    localparam logic [ACTION_W-1:0] ACT_WR_IRQ         = 6'd19;
    localparam logic [ACTION_W-1:0] ACT_WR_IRQ_FORCE   = 6'd20;
    localparam logic [ACTION_W-1:0] ACT_WR_IRQ0_INTE   = 6'd21;
    localparam logic [ACTION_W-1:0] ACT_WR_IRQ0_INTF   = 6'd22;
    localparam logic [ACTION_W-1:0] ACT_WR_IRQ1_INTE   = 6'd23;
    localparam logic [ACTION_W-1:0] ACT_WR_IRQ1_INTF   = 6'd24;
    localparam logic [ACTION_W-1:0] ACT_IN_SYNC_BYPASS = 6'd25;

    // Register byte offsets
    localparam int unsigned REG_CTRL       = 32'h000;
    localparam int unsigned REG_VERSION    = 32'h004;
    localparam int unsigned REG_IRQ        = 32'h008;
    localparam int unsigned REG_IRQ_FORCE  = 32'h00C;
    localparam int unsigned REG_INTR       = 32'h010;
    localparam int unsigned REG_IRQ0_INTE  = 32'h014;
    localparam int unsigned REG_IRQ0_INTF  = 32'h018;
    localparam int unsigned REG_IRQ0_INTS  = 32'h01C;
    localparam int unsigned REG_IRQ1_INTE  = 32'h020;
    localparam int unsigned REG_IRQ1_INTF  = 32'h024;
    localparam int unsigned REG_IRQ1_INTS  = 32'h028;
    localparam int unsigned REG_IN_SYNC    = 32'h02C;
    localparam int unsigned REG_FSTAT      = 32'h030;
    localparam int unsigned REG_TXF_BASE   = 32'h040;
    localparam int unsigned REG_RXF_BASE   = 32'h050;
    localparam int unsigned REG_IMM_BASE   = 32'h060;
    localparam int unsigned REG_SM_BASE    = 32'h080;
    localparam int unsigned REG_INSTR_BASE = 32'h100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/pio_apb_decode.sv
// Address/direction decoder: maps an APB access onto a core action,
// target state machine and instruction slot, and flags illegal accesses.
module pio_apb_decode
    import pio_pkg::*;
#(
    parameter int unsigned NUM_MACHINES = 4,
    parameter int unsigned ADDR_W       = 12
) (
    input  logic [ADDR_W-1:0]   paddr,
    input  logic                pwrite,
    input  logic [NUM_SM-1:0]   tx_full,
    input  logic [NUM_SM-1:0]   rx_empty,
    output logic [ACTION_W-1:0] action,
    output logic [1:0]          mindex,
    output logic [4:0]          index,
    output logic                is_local,
    output logic                err
);

    logic [ADDR_W-1:0]   off;
    logic [1:0]          sm_n;
    logic [ACTION_W-1:0] rd_act;
    logic [ACTION_W-1:0] wr_act;
    logic                rd_ok;
    logic                wr_ok;
    logic                fifo_block;
    logic                unused_lsbs;

    assign off         = {paddr[ADDR_W-1:2], 2'b00};
    assign unused_lsbs = ^paddr[1:0];

    // Region decode: which action each direction maps to and whether it is legal
    always_comb begin
        rd_act     = ACT_NONE;
        wr_act     = ACT_NONE;
        rd_ok      = 1'b0;
        wr_ok      = 1'b0;
        fifo_block = 1'b0;
        sm_n       = off[3:2];
        mindex     = '0;
        index      = '0;
        is_local   = 1'b0;

        if ((off >> 4) == ADDR_W'(REG_TXF_BASE >> 4)) begin
            mindex     = sm_n;
            wr_act     = ACT_PUSH;
            wr_ok      = (32'(sm_n) < NUM_MACHINES);
            fifo_block = pwrite & tx_full[sm_n];
        end else if ((off >> 4) == ADDR_W'(REG_RXF_BASE >> 4)) begin
            mindex     = sm_n;
            rd_act     = ACT_PULL;
            rd_ok      = (32'(sm_n) < NUM_MACHINES);
            fifo_block = ~pwrite & rx_empty[sm_n];
        end else if ((off >> 4) == ADDR_W'(REG_IMM_BASE >> 4)) begin
            mindex = sm_n;
            wr_act = ACT_IMM;
            wr_ok  = (32'(sm_n) < NUM_MACHINES);
        end else if ((off >> 6) == ADDR_W'(REG_SM_BASE >> 6)) begin
            sm_n   = off[5:4];
            mindex = sm_n;
            wr_ok  = (32'(sm_n) < NUM_MACHINES);
            case (off[3:2])
                2'd0:    wr_act = ACT_PEND;
                2'd1:    wr_act = ACT_GRPS;
                2'd2:    wr_act = ACT_DIV;
                default: wr_act = ACT_SHIFT;
            endcase
        end else if ((off >> 7) == ADDR_W'(REG_INSTR_BASE >> 7)) begin
            index  = off[6:2];
            wr_act = ACT_INSTR;
            wr_ok  = 1'b1;
        end else begin
            case (off)
                ADDR_W'(REG_CTRL):      begin wr_act = ACT_EN; wr_ok = 1'b1; end
                ADDR_W'(REG_VERSION):   begin rd_act = ACT_NONE; rd_ok = 1'b1; end
                ADDR_W'(REG_IRQ):       begin rd_act = ACT_RD_IRQ; rd_ok = 1'b1;
                                              wr_act = ACT_WR_IRQ; wr_ok = 1'b1; end
                ADDR_W'(REG_IRQ_FORCE): begin wr_act = ACT_WR_IRQ_FORCE; wr_ok = 1'b1; end
                ADDR_W'(REG_INTR):      begin rd_act = ACT_RD_INTR; rd_ok = 1'b1; end
                ADDR_W'(REG_IRQ0_INTE): begin rd_act = ACT_RD_IRQ0_INTE; rd_ok = 1'b1;
                                              wr_act = ACT_WR_IRQ0_INTE; wr_ok = 1'b1; end
                ADDR_W'(REG_IRQ0_INTF): begin rd_act = ACT_RD_IRQ0_INTF; rd_ok = 1'b1;
                                              wr_act = ACT_WR_IRQ0_INTF; wr_ok = 1'b1; end
                ADDR_W'(REG_IRQ0_INTS): begin rd_act = ACT_RD_IRQ0_INTS; rd_ok = 1'b1; end
                ADDR_W'(REG_IRQ1_INTE): begin rd_act = ACT_RD_IRQ1_INTE; rd_ok = 1'b1;
                                              wr_act = ACT_WR_IRQ1_INTE; wr_ok = 1'b1; end
                ADDR_W'(REG_IRQ1_INTF): begin rd_act = ACT_RD_IRQ1_INTF; rd_ok = 1'b1;
                                              wr_act = ACT_WR_IRQ1_INTF; wr_ok = 1'b1; end
                ADDR_W'(REG_IRQ1_INTS): begin rd_act = ACT_RD_IRQ1_INTS; rd_ok = 1'b1; end
                ADDR_W'(REG_IN_SYNC):   begin wr_act = ACT_IN_SYNC_BYPASS; wr_ok = 1'b1; end
                ADDR_W'(REG_FSTAT):     begin rd_ok = 1'b1; is_local = ~pwrite; end
                default: ;
            endcase
        end
    end

    // An illegal or blocked access never reaches the core
    assign err    = (pwrite ? ~wr_ok : ~rd_ok) | fifo_block;
    assign action = err ? ACT_NONE : (pwrite ? wr_act : rd_act);

endmodule

// File: rtl/pio_apb_bridge.sv
// APB3 slave that turns register accesses into one-cycle PIO core
// action strobes and returns the core's registered read data.
module pio_apb_bridge
    import pio_pkg::*;
#(
    parameter int unsigned NUM_MACHINES = 4,
    parameter int unsigned ADDR_W       = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr,
    output logic [ACTION_W-1:0] action,
    output logic [1:0]          mindex,
    output logic [4:0]          index,
    output logic [DATA_W-1:0]   din,
    input  logic [DATA_W-1:0]   dout,
    input  logic [NUM_SM-1:0]   tx_full,
    input  logic [NUM_SM-1:0]   rx_empty
);

    state_t              state, state_next;
    logic [ACTION_W-1:0] action_next;
    logic [1:0]          mindex_next;
    logic [4:0]          index_next;
    logic [DATA_W-1:0]   din_next;
    logic [DATA_W-1:0]   prdata_next;
    logic                pready_next;
    logic                pslverr_next;
    logic                err_q, err_next;
    logic                rd_q, rd_next;
    logic                local_q, local_next;

    logic [ACTION_W-1:0] dec_action;
    logic [1:0]          dec_mindex;
    logic [4:0]          dec_index;
    logic                dec_local;
    logic                dec_err;
    logic [DATA_W-1:0]   fstat;

    assign fstat = {20'b0, tx_full, 4'b0, rx_empty};

    pio_apb_decode #(
        .NUM_MACHINES (NUM_MACHINES),
        .ADDR_W       (ADDR_W)
    ) u_decode (
        .paddr    (paddr),
        .pwrite   (pwrite),
        .tx_full  (tx_full),
        .rx_empty (rx_empty),
        .action   (dec_action),
        .mindex   (dec_mindex),
        .index    (dec_index),
        .is_local (dec_local),
        .err      (dec_err)
    );

    // Next-state and next-output logic for the transfer sequencer
    always_comb begin
        state_next   = state;
        action_next  = ACT_NONE;
        mindex_next  = mindex;
        index_next   = index;
        din_next     = din;
        prdata_next  = prdata;
        pready_next  = 1'b0;
        pslverr_next = 1'b0;
        err_next     = err_q;
        rd_next      = rd_q;
        local_next   = local_q;

        unique case (state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    action_next = dec_action;
                    mindex_next = dec_mindex;
                    index_next  = dec_index;
                    din_next    = pwdata;
                    err_next    = dec_err;
                    rd_next     = ~pwrite;
                    local_next  = dec_local;
                    state_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rd_q) begin
                    state_next = ST_CAPTURE;
                end else begin
                    prdata_next  = '0;
                    pready_next  = 1'b1;
                    pslverr_next = err_q;
                    state_next   = ST_RESP;
                end
            end
            ST_CAPTURE: begin
                if (err_q) begin
                    prdata_next = '0;
                end else if (local_q) begin
                    prdata_next = fstat;
                end else begin
                    prdata_next = dout;
                end
                pready_next  = 1'b1;
                pslverr_next = err_q;
                state_next   = ST_RESP;
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            action  <= ACT_NONE;
            mindex  <= '0;
            index   <= '0;
            din     <= '0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            local_q <= 1'b0;
        end else begin
            state   <= state_next;
            action  <= action_next;
            mindex  <= mindex_next;
            index   <= index_next;
            din     <= din_next;
            prdata  <= prdata_next;
            pready  <= pready_next;
            pslverr <= pslverr_next;
            err_q   <= err_next;
            rd_q    <= rd_next;
            local_q <= local_next;
        end
    end

endmodule

// File: tb/tb_pio_apb_bridge.sv
// Bench for pio_apb_bridge: directed vectors, reset abort sequence and
// randomized accesses against a table-based register map model.
module tb_pio_apb_bridge;

    localparam int unsigned NUM_MACHINES = 4;
    localparam int unsigned ADDR_W       = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata, prdata;
    logic              pready, pslverr;
    logic [5:0]        action;
    logic [1:0]        mindex;
    logic [4:0]        index;
    logic [31:0]       din, dout;
    logic [3:0]        tx_full, rx_empty;

    always #5 clk = ~clk;

    pio_apb_bridge #(.NUM_MACHINES(NUM_MACHINES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .action(action), .mindex(mindex), .index(index),
        .din(din), .dout(dout), .tx_full(tx_full), .rx_empty(rx_empty)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          lat;
        int          n_act;
        int          act_cyc;
        logic [5:0]  act;
        logic [1:0]  mi;
        logic [4:0]  ix;
        logic [31:0] dn;
        logic        err;
        logic [31:0] prd;
        logic        pre_rdy;
    } obs_t;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] resp;
        logic [3:0]  tf;
        logic [3:0]  re;
        int          exp_act;
        int          exp_mi;
        int          exp_ix;
        logic        exp_err;
        logic        chk_prd;
        logic [31:0] exp_prd;
    } vec_t;

    // Register map model: per word address, legal read/write action (-1 = illegal)
    int rd_code[1024];
    int wr_code[1024];
    int sm_of[1024];
    int ix_of[1024];
    int kind[1024];   // 0 plain, 1 TX FIFO, 2 RX FIFO, 3 local status

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic build_model();
        int cfg_codes[4];
        cfg_codes = '{2, 5, 7, 10};
        for (int w = 0; w < 1024; w++) begin
            rd_code[w] = -1; wr_code[w] = -1; sm_of[w] = 0; ix_of[w] = 0; kind[w] = 0;
        end
        wr_code[0] = 6;
        rd_code[1] = 0;
        rd_code[2] = 11; wr_code[2] = 19;
        wr_code[3] = 20;
        rd_code[4] = 12;
        rd_code[5] = 13; wr_code[5] = 21;
        rd_code[6] = 14; wr_code[6] = 22;
        rd_code[7] = 15;
        rd_code[8] = 16; wr_code[8] = 23;
        rd_code[9] = 17; wr_code[9] = 24;
        rd_code[10] = 18;
        wr_code[11] = 25;
        rd_code[12] = 0; kind[12] = 3;
        for (int n = 0; n < int'(NUM_MACHINES); n++) begin
            wr_code[16+n] = 4; sm_of[16+n] = n; kind[16+n] = 1;
            rd_code[20+n] = 3; sm_of[20+n] = n; kind[20+n] = 2;
            wr_code[24+n] = 9; sm_of[24+n] = n;
            for (int j = 0; j < 4; j++) begin
                wr_code[32+4*n+j] = cfg_codes[j];
                sm_of[32+4*n+j]   = n;
            end
        end
        for (int i = 0; i < 32; i++) begin
            wr_code[64+i] = 1; ix_of[64+i] = i;
        end
    endtask

    // One APB transfer; returns what was observed on the bus and core side
    task automatic xfer(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                        input logic [31:0] resp, input logic [3:0] tf, input logic [3:0] re,
                        input bit scramble, input bit drop_psel, output obs_t o);
        o.lat = 0; o.n_act = 0; o.act_cyc = 0; o.act = '0; o.mi = '0; o.ix = '0;
        o.dn = '0; o.err = 1'b0; o.prd = '0; o.pre_rdy = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        tx_full = tf; rx_empty = re; dout = 32'hA5A5_5A5A;
        @(negedge clk);
        o.pre_rdy = pready;
        if (action != 6'd0) o.n_act++;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            penable = 1'b1;
            psel    = drop_psel ? 1'($urandom_range(0, 1)) : 1'b1;
            dout    = (k == 2) ? resp : (32'hA5A5_5A5A ^ 32'(k));
            if (scramble) begin
                tx_full  = 4'($urandom);
                rx_empty = 4'($urandom);
            end
            @(negedge clk);
            if (action != 6'd0) begin
                o.n_act++; o.act = action; o.act_cyc = k;
                o.mi = mindex; o.ix = index; o.dn = din;
            end
            if (pready) begin
                o.lat = k; o.err = pslverr; o.prd = prdata;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    task automatic verify(input string tag, input obs_t o, input logic wr, input logic [31:0] wd,
                          input int exp_act, input int exp_mi, input int exp_ix,
                          input logic exp_err, input logic chk_prd, input logic [31:0] exp_prd);
        check({tag, " latency"}, 32'(o.lat), wr ? 32'd2 : 32'd3);
        check({tag, " pslverr"}, 32'(o.err), 32'(exp_err));
        check({tag, " setup_pready"}, 32'(o.pre_rdy), 32'd0);
        if (exp_act != 0) begin
            check({tag, " action_pulses"}, 32'(o.n_act), 32'd1);
            check({tag, " action"}, 32'(o.act), 32'(exp_act));
            check({tag, " action_cycle"}, 32'(o.act_cyc), 32'd1);
            check({tag, " mindex"}, 32'(o.mi), 32'(exp_mi));
            check({tag, " index"}, 32'(o.ix), 32'(exp_ix));
            if (wr) check({tag, " din"}, o.dn, wd);
        end else begin
            check({tag, " action_pulses"}, 32'(o.n_act), 32'd0);
        end
        if (chk_prd) check({tag, " prdata"}, o.prd, exp_prd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        obs_t o;

        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; dout = '0; tx_full = '0; rx_empty = '0;
        build_model();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset action", 32'(action), 32'd0);
        check("reset mindex", 32'(mindex), 32'd0);
        check("reset index", 32'(index), 32'd0);
        check("reset din", din, 32'd0);
        check("reset prdata", prdata, 32'd0);
        check("reset pready", 32'(pready), 32'd0);
        check("reset pslverr", 32'(pslverr), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed vectors: wr, addr, wdata, resp, tx_full, rx_empty, act, mi, ix, err, chk_prd, prdata
        vecs.push_back('{1'b1, 12'h104, 32'h0000E081, 32'h0,        4'h0, 4'h0,  1, 0, 1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 12'h004, 32'h0,        32'h01000000, 4'h0, 4'h0,  0, 0, 0, 1'b0, 1'b1, 32'h01000000});
        vecs.push_back('{1'b1, 12'h048, 32'h11111111, 32'h0,        4'h4, 4'h0,  0, 0, 0, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 12'h048, 32'hDEADBEEF, 32'h0,        4'h0, 4'h0,  4, 2, 0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 12'h054, 32'h0,        32'h77777777, 4'h0, 4'h2,  0, 0, 0, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 12'h054, 32'h0,        32'h12345678, 4'h0, 4'h0,  3, 1, 0, 1'b0, 1'b1, 32'h12345678});
        vecs.push_back('{1'b0, 12'h00C, 32'h0,        32'h55555555, 4'h0, 4'h0,  0, 0, 0, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 12'h010, 32'h1,        32'h0,        4'h0, 4'h0,  0, 0, 0, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 12'h1F0, 32'h0,        32'h66666666, 4'h0, 4'h0,  0, 0, 0, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 12'h1F0, 32'h2,        32'h0,        4'h0, 4'h0,  0, 0, 0, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 12'h030, 32'h0,        32'h99999999, 4'hA, 4'h5,  0, 0, 0, 1'b0, 1'b1, 32'h00000A05});
        vecs.push_back('{1'b1, 12'h08C, 32'h00000003, 32'h0,        4'h0, 4'h0, 10, 0, 0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 12'h0B4, 32'h0000ABCD, 32'h0,        4'h0, 4'h0,  5, 3, 0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 12'h014, 32'h0,        32'hCAFEF00D, 4'h0, 4'h0, 13, 0, 0, 1'b0, 1'b1, 32'hCAFEF00D});
        vecs.push_back('{1'b1, 12'h028, 32'h3,        32'h0,        4'h0, 4'h0,  0, 0, 0, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 12'h17C, 32'h0000C0DE, 32'h0,        4'h0, 4'h0,  1, 0, 31, 1'b0, 1'b0, 32'h0});

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].resp, vecs[i].tf, vecs[i].re,
                 vecs[i].addr != 12'h030, 1'b0, o);
            verify($sformatf("vec%0d", i), o, vecs[i].wr, vecs[i].wdata, vecs[i].exp_act,
                   vecs[i].exp_mi, vecs[i].exp_ix, vecs[i].exp_err, vecs[i].chk_prd, vecs[i].exp_prd);
            if (i % 3 == 0) idle(1);
        end
        idle(2);

        // Reset during the ISSUE cycle of an EN write abandons the transfer
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'hF0;
        tx_full = '0; rx_empty = '0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("rst_mid issue_action", 32'(action), 32'd6);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("rst_mid action", 32'(action), 32'd0);
        check("rst_mid pready", 32'(pready), 32'd0);
        check("rst_mid pslverr", 32'(pslverr), 32'd0);
        check("rst_mid din", din, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rst_mid quiet%0d", c), {26'd0, action}, {31'd0, pready});
        end
        xfer(1'b1, 12'h000, 32'h0000000F, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, o);
        verify("rst_after", o, 1'b1, 32'h0000000F, 6, 0, 0, 1'b0, 1'b0, 32'h0);
        idle(1);

        // Randomized accesses against the register map model
        for (int t = 0; t < 250; t++) begin
            logic [ADDR_W-1:0] a;
            logic              wr;
            logic [31:0]       wd, resp, exp_prd;
            logic [3:0]        tf, re;
            int                w, code, exp_act;
            logic              err;

            if ($urandom_range(0, 9) < 8) a = 12'($urandom_range(0, 95) * 4);
            else                          a = 12'($urandom);
            a    = a | 12'($urandom_range(0, 3));
            wr   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            resp = $urandom;
            tf   = 4'($urandom) & 4'($urandom);
            re   = 4'($urandom) & 4'($urandom);
            w    = int'(a >> 2);
            code = wr ? wr_code[w] : rd_code[w];
            err  = (code < 0);
            if (kind[w] == 1 && wr && tf[sm_of[w]]) err = 1'b1;
            if (kind[w] == 2 && !wr && re[sm_of[w]]) err = 1'b1;
            exp_act = err ? 0 : code;
            if (err)               exp_prd = 32'h0;
            else if (kind[w] == 3) exp_prd = {20'b0, tf, 4'b0, re};
            else                   exp_prd = resp;

            xfer(wr, a, wd, resp, tf, re, kind[w] != 3, 1'($urandom_range(0, 1)), o);
            verify($sformatf("rnd%0d@%03h", t, a), o, wr, wd, exp_act, sm_of[w], ix_of[w],
                   err, !wr || err, exp_prd);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
